// File: rtl/execute.sv
// MIPS execute stage: operand select, ALU, branch evaluation and target
// computation, all registered behind a clock enable.
module execute #(
    parameter int DWIDTH       = 32,
    parameter int PC_WIDTH     = 32,
    parameter int IMM_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6
) (
    input  logic                    es_clk,
    input  logic                    es_rst,
    input  logic                    es_i_ce,
    input  logic                    es_i_alu_src,
    input  logic                    es_i_branch,
    input  logic [PC_WIDTH-1:0]     es_i_pc,
    input  logic [IMM_WIDTH-1:0]    es_i_imm,
    input  logic [OPCODE_WIDTH-1:0] es_i_alu_op,
    input  logic [FUNCT_WIDTH-1:0]  es_i_alu_funct,
    input  logic [DWIDTH-1:0]       es_i_data_rs,
    input  logic [DWIDTH-1:0]       es_i_data_rt,
    output logic [DWIDTH-1:0]       es_o_alu_value,
    output logic [PC_WIDTH-1:0]     es_o_alu_pc,
    output logic [OPCODE_WIDTH-1:0] es_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  es_o_funct,
    output logic                    es_o_zero,
    output logic                    es_o_ce,
    output logic                    es_o_change_pc
);

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'b001110;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_WIDTH-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_WIDTH-1:0] FN_SUBU = 6'b100011;
    localparam logic [FUNCT_WIDTH-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_WIDTH-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_WIDTH-1:0] FN_XOR  = 6'b100110;
    localparam logic [FUNCT_WIDTH-1:0] FN_NOR  = 6'b100111;
    localparam logic [FUNCT_WIDTH-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNCT_WIDTH-1:0] FN_SLTU = 6'b101011;
    localparam logic [FUNCT_WIDTH-1:0] FN_SLLV = 6'b000100;
    localparam logic [FUNCT_WIDTH-1:0] FN_SRLV = 6'b000110;
    localparam logic [FUNCT_WIDTH-1:0] FN_SRAV = 6'b000111;

    logic [DWIDTH-1:0]   imm_ext;
    logic [DWIDTH-1:0]   lui_value;
    logic [DWIDTH-1:0]   op_b;
    logic [DWIDTH-1:0]   alu_result;
    logic [4:0]          shamt;
    logic                is_branch_op;
    logic                rs_eq_rt;
    logic                taken;
    logic                zero_flag;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] br_offset;
    logic [PC_WIDTH-1:0] next_pc;

    assign lui_value = {es_i_imm, {(DWIDTH-IMM_WIDTH){1'b0}}};

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        case (es_i_alu_op)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(DWIDTH-IMM_WIDTH){1'b0}}, es_i_imm};
            OP_LUI:                   imm_ext = lui_value;
            default:                  imm_ext = {{(DWIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
        endcase
    end

    assign op_b  = es_i_alu_src ? imm_ext : es_i_data_rt;
    assign shamt = es_i_data_rs[4:0];

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        alu_result = '0;
        case (es_i_alu_op)
            OP_RTYPE: begin
                case (es_i_alu_funct)
                    FN_ADD, FN_ADDU: alu_result = es_i_data_rs + op_b;
                    FN_SUB, FN_SUBU: alu_result = es_i_data_rs - op_b;
                    FN_AND:          alu_result = es_i_data_rs & op_b;
                    FN_OR:           alu_result = es_i_data_rs | op_b;
                    FN_XOR:          alu_result = es_i_data_rs ^ op_b;
                    FN_NOR:          alu_result = ~(es_i_data_rs | op_b);
                    FN_SLT:          alu_result = {{(DWIDTH-1){1'b0}}, $signed(es_i_data_rs) < $signed(op_b)};
                    FN_SLTU:         alu_result = {{(DWIDTH-1){1'b0}}, es_i_data_rs < op_b};
                    FN_SLLV:         alu_result = es_i_data_rt << shamt;
                    FN_SRLV:         alu_result = es_i_data_rt >> shamt;
                    FN_SRAV:         alu_result = $signed(es_i_data_rt) >>> shamt;
                    default:         alu_result = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_result = es_i_data_rs + op_b;
            OP_ANDI:  alu_result = es_i_data_rs & op_b;
            OP_ORI:   alu_result = es_i_data_rs | op_b;
            OP_XORI:  alu_result = es_i_data_rs ^ op_b;
            OP_SLTI:  alu_result = {{(DWIDTH-1){1'b0}}, $signed(es_i_data_rs) < $signed(op_b)};
            OP_SLTIU: alu_result = {{(DWIDTH-1){1'b0}}, es_i_data_rs < op_b};
            OP_LUI:   alu_result = lui_value;
            OP_BEQ, OP_BNE: alu_result = es_i_data_rs - es_i_data_rt;
            default:  alu_result = '0;
        endcase
    end

    // Branches always compare rs against rt, ignoring the operand-B mux.
    assign is_branch_op = (es_i_alu_op == OP_BEQ) || (es_i_alu_op == OP_BNE);
    assign rs_eq_rt     = (es_i_data_rs == es_i_data_rt);
    assign taken        = es_i_branch &&
                          (((es_i_alu_op == OP_BEQ) && rs_eq_rt) ||
                           ((es_i_alu_op == OP_BNE) && !rs_eq_rt));
    assign zero_flag    = is_branch_op ? rs_eq_rt : (alu_result == '0);

    assign pc_plus4  = es_i_pc + PC_WIDTH'(4);
    assign br_offset = {{(PC_WIDTH-IMM_WIDTH-2){es_i_imm[IMM_WIDTH-1]}}, es_i_imm, 2'b00};
    assign next_pc   = taken ? pc_plus4 + br_offset : pc_plus4;

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge es_clk) begin
        if (es_rst) begin
            es_o_alu_value <= '0;
            es_o_alu_pc    <= '0;
            es_o_opcode    <= '0;
            es_o_funct     <= '0;
            es_o_zero      <= 1'b0;
            es_o_ce        <= 1'b0;
            es_o_change_pc <= 1'b0;
        end else if (es_i_ce) begin
            es_o_alu_value <= alu_result;
            es_o_alu_pc    <= next_pc;
            es_o_opcode    <= es_i_alu_op;
            es_o_funct     <= es_i_alu_funct;
            es_o_zero      <= zero_flag;
            es_o_ce        <= 1'b1;
            es_o_change_pc <= taken;
        end else begin
            es_o_ce        <= 1'b0;
            es_o_change_pc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: directed test-plan cases with
// literal expectations, then randomized traffic against a behavioural model.
module tb_execute;

    logic        es_clk = 1'b0;
    logic        es_rst;
    logic        es_i_ce;
    logic        es_i_alu_src;
    logic        es_i_branch;
    logic [31:0] es_i_pc;
    logic [15:0] es_i_imm;
    logic [5:0]  es_i_alu_op;
    logic [5:0]  es_i_alu_funct;
    logic [31:0] es_i_data_rs;
    logic [31:0] es_i_data_rt;
    logic [31:0] es_o_alu_value;
    logic [31:0] es_o_alu_pc;
    logic [5:0]  es_o_opcode;
    logic [5:0]  es_o_funct;
    logic        es_o_zero;
    logic        es_o_ce;
    logic        es_o_change_pc;

    int checks   = 0;
    int failures = 0;

    execute dut (
        .es_clk(es_clk), .es_rst(es_rst), .es_i_ce(es_i_ce),
        .es_i_alu_src(es_i_alu_src), .es_i_branch(es_i_branch),
        .es_i_pc(es_i_pc), .es_i_imm(es_i_imm), .es_i_alu_op(es_i_alu_op),
        .es_i_alu_funct(es_i_alu_funct), .es_i_data_rs(es_i_data_rs),
        .es_i_data_rt(es_i_data_rt), .es_o_alu_value(es_o_alu_value),
        .es_o_alu_pc(es_o_alu_pc), .es_o_opcode(es_o_opcode),
        .es_o_funct(es_o_funct), .es_o_zero(es_o_zero), .es_o_ce(es_o_ce),
        .es_o_change_pc(es_o_change_pc)
    );

    always #5 es_clk = ~es_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected register contents after each edge.
    logic [31:0] m_alu, m_pc;
    logic [5:0]  m_op, m_fn;
    logic        m_zero, m_ce, m_chg;
    bit          model_valid = 0;

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [15:0] imm, input logic src);
        logic [31:0] ext, b;
        logic signed [31:0] srt;
        case (op)
            6'h0C, 6'h0D, 6'h0E: ext = {16'h0, imm};
            6'h0F:               ext = {imm, 16'h0};
            default:             ext = {{16{imm[15]}}, imm};
        endcase
        b   = src ? ext : rt;
        srt = rt;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: return rs + b;
                6'h22, 6'h23: return rs - b;
                6'h24: return rs & b;
                6'h25: return rs | b;
                6'h26: return rs ^ b;
                6'h27: return ~(rs | b);
                6'h2A: return ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: return (rs < b) ? 32'd1 : 32'd0;
                6'h04: return rt << rs[4:0];
                6'h06: return rt >> rs[4:0];
                6'h07: return srt >>> rs[4:0];
                default: return 32'd0;
            endcase
            6'h08, 6'h09, 6'h23, 6'h2B: return rs + b;
            6'h0C: return rs & b;
            6'h0D: return rs | b;
            6'h0E: return rs ^ b;
            6'h0A: return ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
            6'h0B: return (rs < b) ? 32'd1 : 32'd0;
            6'h0F: return {imm, 16'h0};
            6'h04, 6'h05: return rs - rt;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge es_clk) begin
        logic [31:0] r;
        logic        tk;
        if (es_rst) begin
            model_valid = 1;
            {m_alu, m_pc, m_op, m_fn, m_zero, m_ce, m_chg} = '0;
        end else if (es_i_ce) begin
            r  = ref_alu(es_i_alu_op, es_i_alu_funct, es_i_data_rs, es_i_data_rt,
                         es_i_imm, es_i_alu_src);
            tk = es_i_branch && ((es_i_alu_op == 6'h04 && es_i_data_rs == es_i_data_rt) ||
                                 (es_i_alu_op == 6'h05 && es_i_data_rs != es_i_data_rt));
            m_alu  = r;
            m_zero = (es_i_alu_op == 6'h04 || es_i_alu_op == 6'h05) ?
                     (es_i_data_rs == es_i_data_rt) : (r == 0);
            m_pc   = es_i_pc + 32'd4 + (tk ? {{14{es_i_imm[15]}}, es_i_imm, 2'b00} : 32'd0);
            m_op   = es_i_alu_op;
            m_fn   = es_i_alu_funct;
            m_ce   = 1'b1;
            m_chg  = tk;
        end else begin
            m_ce  = 1'b0;
            m_chg = 1'b0;
        end
    end

    always @(negedge es_clk) begin
        if (model_valid) begin
            check("alu_value", 64'(es_o_alu_value), 64'(m_alu));
            check("alu_pc",    64'(es_o_alu_pc),    64'(m_pc));
            check("opcode",    64'(es_o_opcode),    64'(m_op));
            check("funct",     64'(es_o_funct),     64'(m_fn));
            check("zero",      64'(es_o_zero),      64'(m_zero));
            check("ce",        64'(es_o_ce),        64'(m_ce));
            check("change_pc", 64'(es_o_change_pc), 64'(m_chg));
        end
    end

    task automatic drive(input logic ce, input logic src, input logic br,
                         input logic [31:0] pc, input logic [15:0] imm,
                         input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt);
        es_i_ce = ce; es_i_alu_src = src; es_i_branch = br; es_i_pc = pc;
        es_i_imm = imm; es_i_alu_op = op; es_i_alu_funct = fn;
        es_i_data_rs = rs; es_i_data_rt = rt;
    endtask

    task automatic tick();
        @(posedge es_clk);
        #2;
    endtask

    localparam logic [5:0] OPS [13] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                        6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    localparam logic [5:0] FNS [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                        6'h26, 6'h27, 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07};

    initial begin
        es_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        es_rst = 1'b0;
        tick();
        check("reset_alu", 64'(es_o_alu_value), 64'd0);
        check("reset_pc",  64'(es_o_alu_pc),    64'd0);
        check("reset_ce",  64'(es_o_ce),        64'd0);

        drive(1, 0, 0, 32'd10, 16'd0, 6'h00, 6'h20, 32'd5, 32'd4);
        tick();
        check("add_alu", 64'(es_o_alu_value), 64'd9);
        check("add_zero", 64'(es_o_zero), 64'd0);
        check("add_pc", 64'(es_o_alu_pc), 64'd14);
        check("add_chg", 64'(es_o_change_pc), 64'd0);
        check("add_ce", 64'(es_o_ce), 64'd1);
        check("add_funct", 64'(es_o_funct), 64'h20);

        drive(1, 0, 0, 32'd10, 16'd0, 6'h00, 6'h22, 32'd5, 32'd4);
        tick();
        check("sub_alu", 64'(es_o_alu_value), 64'd1);
        drive(1, 0, 0, 32'd10, 16'd0, 6'h00, 6'h22, 32'd4, 32'd4);
        tick();
        check("sub_eq_alu", 64'(es_o_alu_value), 64'd0);
        check("sub_eq_zero", 64'(es_o_zero), 64'd1);

        drive(1, 1, 1, 32'd10, 16'd10, 6'h04, 6'h00, 32'd5, 32'd6);
        tick();
        check("beq_nt_chg", 64'(es_o_change_pc), 64'd0);
        check("beq_nt_pc", 64'(es_o_alu_pc), 64'd14);

        drive(1, 1, 0, 32'd10, 16'hFFFF, 6'h08, 6'h00, 32'd5, 32'd0);
        tick();
        check("addi_alu", 64'(es_o_alu_value), 64'd4);
        drive(1, 1, 0, 32'd10, 16'h8000, 6'h0D, 6'h00, 32'd0, 32'd0);
        tick();
        check("ori_alu", 64'(es_o_alu_value), 64'h8000);

        drive(1, 1, 1, 32'd10, 16'd10, 6'h04, 6'h00, 32'd5, 32'd5);
        tick();
        check("beq_t_chg", 64'(es_o_change_pc), 64'd1);
        check("beq_t_zero", 64'(es_o_zero), 64'd1);
        check("beq_t_pc", 64'(es_o_alu_pc), 64'd54);

        drive(0, 0, 0, 32'd99, 16'd1, 6'h00, 6'h20, 32'd7, 32'd1);
        tick();
        check("hold_ce", 64'(es_o_ce), 64'd0);
        check("hold_chg", 64'(es_o_change_pc), 64'd0);
        check("hold_pc", 64'(es_o_alu_pc), 64'd54);
        check("hold_op", 64'(es_o_opcode), 64'h04);

        drive(1, 0, 0, 32'd10, 16'd0, 6'h00, 6'h20, 32'd5, 32'd4);
        es_rst = 1'b1;
        tick();
        es_rst = 1'b0;
        check("midrst_alu", 64'(es_o_alu_value), 64'd0);
        check("midrst_pc", 64'(es_o_alu_pc), 64'd0);
        check("midrst_ce", 64'(es_o_ce), 64'd0);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rs, rt;
            logic [5:0]  op, fn;
            rs = $urandom();
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom();
            if ($urandom_range(0, 3) == 0) rs = $urandom_range(0, 40) - 20;
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom()) : OPS[$urandom_range(0, 12)];
            fn = ($urandom_range(0, 15) == 0) ? 6'($urandom()) : FNS[$urandom_range(0, 12)];
            drive($urandom_range(0, 4) != 0, 1'($urandom()), $urandom_range(0, 3) != 0,
                  $urandom(), 16'($urandom()), op, fn, rs, rt);
            es_rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        es_rst = 1'b0;
        tick();
        @(negedge es_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
